mips_multicycle_ctrl: RTL and testbench

Multicycle control unit for the MIPS datapath. It decodes `op`/`funct` from the instruction register and sequences a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the write enables and the 3-bit `alucontrol` consumed by the ALU. It also takes the ALU `zero` flag back to resolve branches, and so sits between the instruction register and the datapath/ALU.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 63 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 31 +++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU control values, datapath select encodings and the FSM state set.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                        op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the controller.
// master = controller side, slave = datapath / instruction register side.
interface mips_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decode from the FSM's aluop and the funct field.
// funct_illegal reflects the funct field alone so DECODE can flag it early.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  logic [2:0] funct_alu;

  always_comb begin
    funct_alu     = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FUNCT_ADD: funct_alu = ALU_ADD;
      FUNCT_SUB: funct_alu = ALU_SUB;
      FUNCT_AND: funct_alu = ALU_AND;
      FUNCT_OR:  funct_alu = ALU_OR;
      FUNCT_SLT: funct_alu = ALU_SLT;
      FUNCT_MUL: funct_alu = ALU_MUL;
      default:   funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_alu;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs per state, with pcen also
// qualified by the ALU zero flag during BEQEX.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mips_ctrl_if.master    bus
);

  state_t     state_reg;
  state_t     state_next;
  state_t     out_state;
  aluop_t     aluop;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       decode_illegal;
  logic [2:0] alucontrol;
  logic       funct_illegal;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  // Under reset the selects already show FETCH even if the state register
  // is still mid-instruction; the strobes are gated separately below.
  assign out_state = reset ? FETCH : state_reg;

  always_comb begin
    aluop          = ALUOP_ADD;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    iord           = 1'b0;
    memwrite       = 1'b0;
    irwrite        = 1'b0;
    regdst         = 1'b0;
    memtoreg       = 1'b0;
    regwrite       = 1'b0;
    alusrca        = 1'b0;
    alusrcb        = SRCB_REG;
    pcsrc          = PCSRC_ALU;
    decode_illegal = 1'b0;
    case (out_state)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb        = SRCB_IMM_SH2;
        decode_illegal = !op_supported(bus.op) ||
                         ((bus.op == OP_RTYPE) && funct_illegal);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop         (aluop),
    .funct         (bus.funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  // branch is only ever set in BEQEX, so zero cannot leak into pcen elsewhere.
  assign bus.pcen       = !reset && (pcwrite || (branch && bus.zero));
  assign bus.irwrite    = !reset && irwrite;
  assign bus.regwrite   = !reset && regwrite;
  assign bus.memwrite   = !reset && memwrite;
  assign bus.illegal    = !reset && decode_illegal;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: each stimulus cycle queues the expected control word; a
// negedge monitor pops and compares it against the live outputs.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;

  mips_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] v;
    logic [15:0] m;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [15:0] M_ALL   = 16'hFFFF;
  localparam logic [15:0] M_NOALU = 16'hFFF1;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  function automatic logic [15:0] ev(
    input logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    input logic [1:0] alusrcb, pcsrc, input logic [2:0] aluc, input logic ill);
    ev = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
          alusrcb, pcsrc, aluc, ill};
  endfunction

  function automatic logic [15:0] actual();
    actual = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
              bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
  endfunction

  // Queue one cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic [15:0] v, input logic [15:0] m);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    e.m  = m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = actual();
      checks++;
      if (((a ^ e.v) & e.m) != 16'h0) begin
        errors++;
        $display("FAIL %s: got %04h expected %04h (mask %04h)", e.nm, a, e.v, e.m);
      end else begin
        $display("ok   %s: %04h", e.nm, a);
      end
    end
  end

  logic [15:0] e_rst, e_fetch, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [15:0] e_rwb, e_addiex, e_addiwb, e_jex;

  function automatic logic [15:0] e_rex(input logic [2:0] aluc);
    e_rex = ev(0,0,0,0,0,0,0,1, 2'b00, 2'b00, aluc, 0);
  endfunction

  function automatic logic [15:0] e_beq(input logic z);
    e_beq = ev(z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
  endfunction

  task automatic run_rtype(input logic [5:0] f, input logic [2:0] aluc, input logic ill);
    bus.op    = 6'b000000;
    bus.funct = f;
    cyc("rtype_fetch",  e_fetch, M_ALL);
    cyc("rtype_decode", ill ? e_decode_ill : e_decode, M_ALL);
    cyc("rtypeex",      e_rex(aluc), M_ALL);
    cyc("rtypewb",      e_rwb, M_NOALU);
  endtask

  initial begin
    e_rst        = ev(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    e_fetch      = ev(1,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    e_decode     = ev(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
    e_decode_ill = ev(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 1);
    e_memadr     = ev(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    e_memrd      = ev(0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    e_memwb      = ev(0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 0);
    e_memwr      = ev(0,1,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    e_rwb        = ev(0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 0);
    e_addiex     = ev(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    e_addiwb     = ev(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000, 0);
    e_jex        = ev(1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0);

    reset     = 1'b1;
    bus.op    = 6'b100011;
    bus.funct = 6'b100000;
    bus.zero  = 1'b0;
    @(posedge clk);
    #1;

    cyc("reset0", e_rst, M_ALL);
    cyc("reset1", e_rst, M_ALL);
    reset = 1'b0;

    // lw
    bus.op = 6'b100011;
    cyc("lw_fetch",  e_fetch,  M_ALL);
    cyc("lw_decode", e_decode, M_ALL);
    cyc("lw_memadr", e_memadr, M_ALL);
    cyc("lw_memrd",  e_memrd,  M_NOALU);
    cyc("lw_memwb",  e_memwb,  M_NOALU);

    // sw
    bus.op = 6'b101011;
    cyc("sw_fetch",  e_fetch,  M_ALL);
    cyc("sw_decode", e_decode, M_ALL);
    cyc("sw_memadr", e_memadr, M_ALL);
    cyc("sw_memwr",  e_memwr,  M_NOALU);

    run_rtype(6'b100010, 3'b110, 1'b0);
    run_rtype(6'b101010, 3'b111, 1'b0);
    run_rtype(6'b011000, 3'b101, 1'b0);
    run_rtype(6'b100101, 3'b001, 1'b0);
    run_rtype(6'b000001, 3'b010, 1'b1);

    // beq taken; zero raised during DECODE must not reach pcen
    bus.op   = 6'b000100;
    bus.zero = 1'b0;
    cyc("beq_fetch",  e_fetch, M_ALL);
    bus.zero = 1'b1;
    cyc("beq_decode_zero", e_decode, M_ALL);
    cyc("beqex_taken", e_beq(1'b1), M_ALL);
    bus.zero = 1'b0;
    cyc("beq2_fetch",  e_fetch,  M_ALL);
    cyc("beq2_decode", e_decode, M_ALL);
    cyc("beqex_not_taken", e_beq(1'b0), M_ALL);

    // addi
    bus.op = 6'b001000;
    cyc("addi_fetch",  e_fetch,  M_ALL);
    cyc("addi_decode", e_decode, M_ALL);
    cyc("addiex",      e_addiex, M_ALL);
    cyc("addiwb",      e_addiwb, M_NOALU);

    // j
    bus.op = 6'b000010;
    cyc("j_fetch",  e_fetch,  M_ALL);
    cyc("j_decode", e_decode, M_ALL);
    cyc("jex",      e_jex,    M_NOALU);

    // illegal opcode returns straight to FETCH
    bus.op = 6'b111111;
    cyc("ill_fetch",  e_fetch,      M_ALL);
    cyc("ill_decode", e_decode_ill, M_ALL);
    bus.op = 6'b100011;
    cyc("ill_back_fetch", e_fetch,  M_ALL);

    // reset asserted in MEMRD of an lw
    cyc("rlw_decode", e_decode, M_ALL);
    cyc("rlw_memadr", e_memadr, M_ALL);
    reset = 1'b1;
    cyc("rlw_reset_in_memrd", e_rst, M_ALL);
    reset = 1'b0;
    cyc("rlw_after_reset_fetch", e_fetch,  M_ALL);
    cyc("rlw2_decode",           e_decode, M_ALL);
    cyc("rlw2_memadr",           e_memadr, M_ALL);
    cyc("rlw2_memrd",            e_memrd,  M_NOALU);
    cyc("rlw2_memwb",            e_memwb,  M_NOALU);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
